// File: rtl/spike_router_pkg.sv
// Shared types and helpers for the spike dispatch scheduler: LUT entry layout,
// default widths, and per-row slicing of packed address buses.
package spike_router_pkg;

   localparam int DEFAULT_NUM_SYNAPSE_ROWS = 4;
   localparam int DEFAULT_ADDR_WIDTH       = 6;
   localparam int DEFAULT_DROP_CNT_WIDTH   = 16;

   // LUT entries are sized for the default row count and address width.
   localparam int LUT_ROW_W  = $clog2(DEFAULT_NUM_SYNAPSE_ROWS);
   localparam int LUT_ADDR_W = DEFAULT_ADDR_WIDTH;
   localparam int ROW_BUS_W  = DEFAULT_NUM_SYNAPSE_ROWS * LUT_ADDR_W;

   typedef struct packed {
      logic                  enable;
      logic [LUT_ROW_W-1:0]  row;
      logic [LUT_ADDR_W-1:0] address;
   } lut_entry_t;

   function automatic logic [LUT_ADDR_W-1:0] row_address(
      input logic [ROW_BUS_W-1:0] bus,
      input int                   row
   );
      return bus[row*LUT_ADDR_W +: LUT_ADDR_W];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int W = $clog2(N);

   logic [W-1:0] scan_idx;

   // NOTE: every variable written here gets a default before the loop, so no
   // path leaves a value held over from a previous evaluation (no latch).
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      // Scan farthest-first so the nearest requester to the pointer wins last.
      for (int k = N - 1; k >= 0; k--) begin
         scan_idx = W'((int'(ptr) + k) % N);
         if (req[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

endmodule

// File: rtl/spike_dispatch_scheduler.sv
// Merges per-row external stimulus with LUT-translated neuron column spikes,
// buffering column spikes in a pending bitmap and dispatching one per cycle.
module spike_dispatch_scheduler
   import spike_router_pkg::*;
#(
   parameter int NUM_COLS         = 4,
   parameter int NUM_SYNAPSE_ROWS = DEFAULT_NUM_SYNAPSE_ROWS,
   parameter int ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
   parameter int DROP_CNT_WIDTH   = DEFAULT_DROP_CNT_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_COLS-1:0]                    spike_in_valid,
   input  logic [NUM_SYNAPSE_ROWS-1:0]            ext_valid,
   input  logic [NUM_SYNAPSE_ROWS-1:0]            ext_on_off,
   input  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] ext_address,
   input  logic                                   lut_we,
   input  logic [$clog2(NUM_COLS)-1:0]            lut_col,
   input  logic                                   lut_enable,
   input  logic [$clog2(NUM_SYNAPSE_ROWS)-1:0]    lut_row,
   input  logic [ADDR_WIDTH-1:0]                  lut_address,
   output logic [NUM_SYNAPSE_ROWS-1:0]            out_valid,
   output logic [NUM_SYNAPSE_ROWS-1:0]            out_on_off,
   output logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] out_address,
   output logic [NUM_COLS-1:0]                    pending,
   output logic [DROP_CNT_WIDTH-1:0]              drop_count
);

   localparam int COL_W = $clog2(NUM_COLS);

   lut_entry_t                            lut [NUM_COLS];
   logic [COL_W-1:0]                      ptr;

   logic [NUM_COLS-1:0]                   candidate;
   logic [NUM_COLS-1:0]                   capture_mask;
   logic [NUM_COLS-1:0]                   grant_onehot;
   logic [NUM_COLS-1:0]                   drop_mask;
   logic [NUM_COLS-1:0]                   pending_next;
   logic                                  grant_valid;
   logic [COL_W-1:0]                      grant_idx;
   lut_entry_t                            grant_entry;
   logic                                  lut_write_ok;

   logic [NUM_SYNAPSE_ROWS-1:0]            out_valid_next;
   logic [NUM_SYNAPSE_ROWS-1:0]            out_on_off_next;
   logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] out_address_next;
   logic [DROP_CNT_WIDTH:0]                drop_sum;
   logic [DROP_CNT_WIDTH-1:0]              drop_count_next;

   // A pending column competes only if its target row is free of external
   // stimulus this cycle; a blocked column simply waits.
   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) begin
         candidate[c]    = pending[c] & ~ext_valid[lut[c].row];
         capture_mask[c] = spike_in_valid[c] & lut[c].enable;
      end
   end

   rr_arbiter #(.N(NUM_COLS)) u_arbiter (
      .req         (candidate),
      .ptr         (ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign grant_entry = lut[grant_idx];

   always_comb begin
      grant_onehot = '0;
      if (grant_valid) grant_onehot[grant_idx] = 1'b1;
   end

   // A re-spike on the column being granted this edge replaces the one
   // leaving, so it is kept rather than dropped.
   assign drop_mask    = capture_mask & pending & ~grant_onehot;
   assign pending_next = (pending & ~grant_onehot) | capture_mask;

   assign drop_sum        = {1'b0, drop_count} + (DROP_CNT_WIDTH+1)'($countones(drop_mask));
   assign drop_count_next = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];

   // External stimulus owns its row; the arbiter already excluded such rows,
   // so the network branch never collides with it.
   always_comb begin
      out_valid_next   = '0;
      out_on_off_next  = '0;
      out_address_next = '0;
      for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
         if (ext_valid[r]) begin
            out_valid_next[r]                             = 1'b1;
            out_on_off_next[r]                            = ext_on_off[r];
            out_address_next[r*ADDR_WIDTH +: ADDR_WIDTH]  = row_address(ext_address, r);
         end else if (grant_valid && grant_entry.enable && 32'(grant_entry.row) == r) begin
            out_valid_next[r]                             = 1'b1;
            out_on_off_next[r]                            = 1'b1;
            out_address_next[r*ADDR_WIDTH +: ADDR_WIDTH]  = grant_entry.address;
         end
      end
   end

   assign lut_write_ok = lut_we
                         && (32'(lut_col) < NUM_COLS)
                         && (32'(lut_row) < NUM_SYNAPSE_ROWS);

   // NOTE: the LUT is a handful of flops, not a RAM, so it is reset with the
   // rest of the state; after reset every column is disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_COLS; c++) lut[c] <= '0;
      end else if (lut_write_ok) begin
         lut[lut_col] <= '{enable: lut_enable, row: lut_row, address: lut_address};
      end
   end

   // NOTE: state updates use non-blocking assignments so every register sees
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr         <= '0;
         pending     <= '0;
         out_valid   <= '0;
         out_on_off  <= '0;
         out_address <= '0;
         drop_count  <= '0;
      end else begin
         pending     <= pending_next;
         out_valid   <= out_valid_next;
         out_on_off  <= out_on_off_next;
         out_address <= out_address_next;
         drop_count  <= drop_count_next;
         if (grant_valid) begin
            ptr <= (32'(grant_idx) == NUM_COLS - 1) ? '0 : grant_idx + COL_W'(1);
         end
      end
   end

endmodule

// File: doc/spike_dispatch_scheduler.md
Name: spike_dispatch_scheduler

Overview:
- Replaces the pass-through path between the neural network and the synapse-row drivers.
- Merges per-row external stimulus with spikes from the NUM_COLS neuron columns.
- Each column is translated through a writable lookup table (column -> target row, synapse address).
- Buffers column spikes in a pending bitmap and dispatches at most one network spike per cycle by round-robin; external stimulus has priority on its row.

Parameters:
NUM_COLS, 4, number of neuron columns (spike sources)
NUM_SYNAPSE_ROWS, 4, number of synapse-row outputs
ADDR_WIDTH, 6, synapse address width
DROP_CNT_WIDTH, 16, width of saturating drop counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
spike_in_valid  in  NUM_COLS  one-cycle spike pulse per column, no backpressure
ext_valid  in  NUM_SYNAPSE_ROWS  external stimulus valid per row
ext_on_off  in  NUM_SYNAPSE_ROWS  external stimulus on/off flag per row
ext_address  in  NUM_SYNAPSE_ROWS*ADDR_WIDTH  external stimulus address, row r at [r*ADDR_WIDTH +: ADDR_WIDTH]
lut_we  in  1  LUT write strobe
lut_col  in  $clog2(NUM_COLS)  LUT entry index
lut_enable  in  1  entry enable
lut_row  in  $clog2(NUM_SYNAPSE_ROWS)  target row
lut_address  in  ADDR_WIDTH  target synapse address
out_valid  out  NUM_SYNAPSE_ROWS  spike valid per row
out_on_off  out  NUM_SYNAPSE_ROWS  on/off per row
out_address  out  NUM_SYNAPSE_ROWS*ADDR_WIDTH  address per row, same packing as ext_address
pending  out  NUM_COLS  pending-spike bitmap (status)
drop_count  out  DROP_CNT_WIDTH  saturating count of dropped column spikes

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; pending 0; round-robin pointer 0; drop_count 0.
  - all LUT entries {enable=0, row=0, address=0}.
  - Reset mid-operation discards all pending spikes.
- All outputs are registered.
- External path, latency 1:
  - ext_valid[r] sampled at edge E -> out_valid[r]=1 after E, with ext_on_off[r] and ext_address[r].
- LUT write:
  - on edge with lut_we=1, entry lut_col updated; visible from next cycle.
  - Out-of-range lut_col or lut_row: write ignored.
- Capture, at each edge for column c with spike_in_valid[c]=1:
  - LUT[c].enable=0: spike discarded, not counted.
  - pending[c]=0: pending[c] set.
  - pending[c]=1 and c not granted this edge: spike dropped; drop_count+1, saturating at all-ones.
  - pending[c]=1 and c granted this edge: pending[c] stays 1 (new spike kept), no drop.
- Arbitration (combinational on registered state, each cycle):
  - Candidate set = pending columns whose LUT[c].row has ext_valid=0 in the same cycle.
  - Grant = first candidate at or after the pointer, wrapping modulo NUM_COLS.
  - At most one grant per cycle.
- Dispatch on grant g at edge E:
  - pending[g] cleared (unless re-set per the capture rule).
  - out_valid[row]=1, out_on_off[row]=1, out_address[row]=LUT[g].address after E.
  - pointer <= (g+1) mod NUM_COLS.
  - LUT contents are read at dispatch time, not at capture time.
- Minimum latency, column spike to output: 2 edges.
- No candidate: pointer holds; no network output.
- Row blocked by ext_valid: the column stays pending (no loss); other columns may be granted.
- A row's output never carries both an external and a network spike in the same cycle.
- Entry disabled while pending: at dispatch, the entry is cleared without output.

Decomposition:
- Package spike_router_pkg:
  - lut_entry_t struct {enable, row, address}
  - DROP_CNT_WIDTH default
  - helper function to slice packed per-row addresses
- Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs grant_valid and grant_idx (find-first-from-pointer with wrap); purely combinational.

Test Plan:
- Reset: assert reset mid-traffic with pending=4'b1011 -> after reset, pending=0, all out_valid=0, drop_count=0, LUT disabled.
- External feed-through: ext_valid[2]=1, on_off=0, addr=6'h15 at edge E -> out_valid=4'b0100, on_off[2]=0, out_address[2]=6'h15 after E, for exactly one cycle.
- Round-robin fairness: LUT cols 0..3 -> rows 0..3, addr=c+8; all four columns spike at edge E -> one dispatch per cycle on rows 0,1,2,3 at E+1..E+4.
- Priority/blocking: col1 -> row2; col1 spikes at E; ext_valid[2] held high E+1..E+3 -> network spike on row 2 after E+4, no loss, drop_count=0.
- Drop counting: col0 spikes at E and E+1 while blocked -> drop_count=1; preload drop_count near all-ones and repeat -> saturates, never wraps.
- Simultaneous grant and re-spike: col3 granted at edge E while spiking again -> output after E, pending[3]=1 after E, second output after E+1, drop_count unchanged.
